// File: rtl/laser310_pkg.sv
// Shared constants and state encoding for the Laser310 VZ image loader.
package laser310_pkg;

    localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
    localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;

    // Magic bytes in file order, byte 0 in the top lane
    localparam logic [31:0] MAGIC_VZF0    = 32'h565A_4630;
    localparam logic [31:0] MAGIC_ALT     = 32'h2020_0000;

    localparam logic [15:0] HDR_TYPE_OFS  = 16'd21;
    localparam logic [15:0] HDR_LO_OFS    = 16'd22;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_PATCH0,
        S_PATCH1,
        S_PATCH2,
        S_PATCH3,
        S_DONE,
        S_ERR
    } vz_state_t;

    function automatic logic [7:0] magic_byte(
        input logic [31:0] m,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = m[31:24];
            2'd1:    b = m[23:16];
            2'd2:    b = m[15:8];
            default: b = m[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vz_image_loader.sv
// Parses a VZ image from the hps ioctl stream, writes its payload into
// Laser310 RAM and patches the BASIC end pointer or USR vector afterwards.
module vz_image_loader
    import laser310_pkg::*;
#(
    parameter logic [7:0]  VZ_INDEX      = 8'd1,
    parameter int          HDR_LEN       = 24,
    parameter logic [15:0] PTR_BASIC_END = 16'h78F9,
    parameter logic [15:0] PTR_USR       = 16'h788E,
    parameter bit          CHECK_MAGIC   = 1'b1
) (
    input  logic        CLK42MHZ,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        dn_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic        ram_ack,
    output logic        busy,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  vz_type,
    output logic [15:0] vz_start
);

    localparam logic [15:0] HDR_LAST = 16'(HDR_LEN - 1);

    vz_state_t   state, state_n;
    logic        active, active_q, rise, fall;
    logic [15:0] cnt, cnt_n, cnt_inc;
    logic [15:0] wptr, wptr_n;
    logic [7:0]  vz_type_n;
    logic [15:0] vz_start_n;
    logic [15:0] ram_addr_n;
    logic [7:0]  ram_wdata_n;
    logic        ram_we_n, dn_wait_n, load_err_n;
    logic        mag_vz, mag_vz_n, mag_alt, mag_alt_n;
    logic        type_ok, magic_ok, is_basic;
    logic [15:0] patch_base, patch_val;
    logic        unused_addr;

    // Bytes are consumed in strobe order; the file offset carries no information
    assign unused_addr = ^dn_addr;

    assign active  = dn_download && (dn_index == VZ_INDEX);
    assign rise    = active && !active_q;
    assign fall    = !active && active_q;
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    assign type_ok  = (vz_type == VZ_TYPE_BASIC) || (vz_type == VZ_TYPE_BIN);
    assign magic_ok = !CHECK_MAGIC || mag_vz || mag_alt;
    assign is_basic = (vz_type == VZ_TYPE_BASIC);

    assign patch_base = is_basic ? PTR_BASIC_END : PTR_USR;
    assign patch_val  = is_basic ? wptr : vz_start;

    assign busy      = !(state inside {S_IDLE, S_DONE, S_ERR});
    assign load_done = (state == S_DONE);

    always_ff @(posedge CLK42MHZ or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            active_q  <= 1'b0;
            cnt       <= '0;
            wptr      <= '0;
            vz_type   <= '0;
            vz_start  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            dn_wait   <= 1'b0;
            load_err  <= 1'b0;
            mag_vz    <= 1'b0;
            mag_alt   <= 1'b0;
        end else begin
            state     <= state_n;
            active_q  <= active;
            cnt       <= cnt_n;
            wptr      <= wptr_n;
            vz_type   <= vz_type_n;
            vz_start  <= vz_start_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
            ram_we    <= ram_we_n;
            dn_wait   <= dn_wait_n;
            load_err  <= load_err_n;
            mag_vz    <= mag_vz_n;
            mag_alt   <= mag_alt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wptr_n      = wptr;
        vz_type_n   = vz_type;
        vz_start_n  = vz_start;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        ram_we_n    = ram_we;
        dn_wait_n   = dn_wait;
        load_err_n  = load_err;
        mag_vz_n    = mag_vz;
        mag_alt_n   = mag_alt;

        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n    = S_HDR;
                    cnt_n      = '0;
                    load_err_n = 1'b0;
                    mag_vz_n   = 1'b1;
                    mag_alt_n  = 1'b1;
                end
            end
            S_HDR: begin
                if (dn_wr) begin
                    cnt_n = cnt_inc;
                    if (cnt < 16'd4) begin
                        mag_vz_n  = mag_vz &&
                            (dn_data == magic_byte(MAGIC_VZF0, cnt[1:0]));
                        mag_alt_n = mag_alt &&
                            (dn_data == magic_byte(MAGIC_ALT, cnt[1:0]));
                    end
                    if (cnt == HDR_TYPE_OFS)
                        vz_type_n = dn_data;
                    if (cnt == HDR_LO_OFS)
                        vz_start_n[7:0] = dn_data;
                    if (cnt == HDR_LAST) begin
                        vz_start_n[15:8] = dn_data;
                        wptr_n = {dn_data, vz_start[7:0]};
                        state_n = (type_ok && magic_ok) ? S_DATA : S_ERR;
                    end
                end else if (fall) begin
                    state_n = S_ERR;
                end
            end
            S_DATA: begin
                if (dn_wr) begin
                    cnt_n       = cnt_inc;
                    ram_addr_n  = wptr;
                    ram_wdata_n = dn_data;
                    ram_we_n    = 1'b1;
                    dn_wait_n   = 1'b1;
                    state_n     = S_WR;
                end else if (fall) begin
                    state_n = S_PATCH0;
                end
            end
            S_WR: begin
                // A strobe here means hps ignored dn_wait; the byte is lost
                if (dn_wr)
                    load_err_n = 1'b1;
                if (ram_ack) begin
                    ram_we_n  = 1'b0;
                    dn_wait_n = 1'b0;
                    wptr_n    = wptr + 16'd1;
                    state_n   = active ? S_DATA : S_PATCH0;
                end
            end
            S_PATCH0: begin
                ram_addr_n  = patch_base;
                ram_wdata_n = patch_val[7:0];
                ram_we_n    = 1'b1;
                state_n     = S_PATCH1;
            end
            S_PATCH1: begin
                if (ram_ack) begin
                    ram_we_n = 1'b0;
                    state_n  = S_PATCH2;
                end
            end
            S_PATCH2: begin
                ram_addr_n  = patch_base + 16'd1;
                ram_wdata_n = patch_val[15:8];
                ram_we_n    = 1'b1;
                state_n     = S_PATCH3;
            end
            S_PATCH3: begin
                if (ram_ack) begin
                    ram_we_n = 1'b0;
                    state_n  = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            S_ERR: begin
                ram_we_n  = 1'b0;
                dn_wait_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (state_n == S_ERR)
            load_err_n = 1'b1;
    end

endmodule

// File: tb/tb_vz_image_loader.sv
// Directed bench for vz_image_loader: header parsing, payload writes,
// pointer patching, error paths and mid-load reset.
module tb_vz_image_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dn_download;
    logic [7:0]  dn_index;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_ack;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic [7:0]  vz_type;
    logic [15:0] vz_start;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [logic [15:0]];
    int         wr_cnt = 0;
    int         ack_delay = 0;
    int         dcnt = 0;
    int         done_cnt = 0;
    int         wait_hi = 0;
    bit         busy_seen = 0;
    logic [7:0] q [$];

    always #5 clk = ~clk;

    vz_image_loader dut (
        .CLK42MHZ    (clk),
        .RESET       (rst_n),
        .dn_download (dn_download),
        .dn_index    (dn_index),
        .dn_wr       (dn_wr),
        .dn_addr     (dn_addr),
        .dn_data     (dn_data),
        .dn_wait     (dn_wait),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_ack     (ram_ack),
        .busy        (busy),
        .load_done   (load_done),
        .load_err    (load_err),
        .vz_type     (vz_type),
        .vz_start    (vz_start)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] rd(input logic [15:0] a);
        if (mem.exists(a))
            return {1'b0, mem[a]};
        return 9'h1FF;
    endfunction

    // RAM model: acknowledges each request after ack_delay extra cycles
    initial begin
        ram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ram_ack) begin
                ram_ack = 1'b0;
                dcnt = 0;
            end else if (!ram_we) begin
                dcnt = 0;
            end else if (dcnt >= ack_delay) begin
                mem[ram_addr] = ram_wdata;
                wr_cnt++;
                ram_ack = 1'b1;
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (load_done)
                done_cnt++;
            if (dn_wait && ram_we)
                wait_hi++;
            if (busy)
                busy_seen = 1'b1;
        end
    end

    task automatic build_hdr(input logic [31:0] magic, input logic [7:0] typ,
                             input logic [15:0] start);
        logic [31:0] m;
        m = magic;
        q.delete();
        q.push_back(m[31:24]);
        q.push_back(m[23:16]);
        q.push_back(m[15:8]);
        q.push_back(m[7:0]);
        for (int i = 0; i < 17; i++)
            q.push_back(8'h41 + 8'(i));
        q.push_back(typ);
        q.push_back(start[7:0]);
        q.push_back(start[15:8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [15:0] ofs);
        int n;
        n = 0;
        while (dn_wait && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300)
            chk("dn_wait_timeout", 1, 0);
        dn_data = b;
        dn_addr = ofs;
        dn_wr = 1'b1;
        @(posedge clk);
        #1;
        dn_wr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        dn_index = idx;
        dn_download = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_dl();
        int n;
        dn_download = 1'b0;
        n = 0;
        @(posedge clk);
        #1;
        while (busy && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500)
            chk("busy_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic load_file(input logic [7:0] idx);
        start_dl(idx);
        foreach (q[i])
            send_byte(q[i], 16'(i));
        end_dl();
    endtask

    initial begin
        int d0;
        int w0;
        rst_n = 1'b0;
        dn_download = 1'b0;
        dn_index = 8'd0;
        dn_wr = 1'b0;
        dn_addr = '0;
        dn_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {busy, ram_we, dn_wait, load_err, load_done, vz_type, vz_start},
            '0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // F0 load, single-cycle ack
        build_hdr(32'h565A4630, 8'hF0, 16'h7AE9);
        for (int i = 0; i < 5; i++)
            q.push_back(8'h11 * 8'(i + 1));
        d0 = done_cnt;
        load_file(8'd1);
        chk("f0_7ae9", rd(16'h7AE9), 9'h011);
        chk("f0_7aea", rd(16'h7AEA), 9'h022);
        chk("f0_7aeb", rd(16'h7AEB), 9'h033);
        chk("f0_7aec", rd(16'h7AEC), 9'h044);
        chk("f0_7aed", rd(16'h7AED), 9'h055);
        chk("f0_ptr_lo", rd(16'h78F9), 9'h0EE);
        chk("f0_ptr_hi", rd(16'h78FA), 9'h07A);
        chk("f0_writes", wr_cnt, 7);
        chk("f0_done", done_cnt - d0, 1);
        chk("f0_err", load_err, 0);
        chk("f0_type", vz_type, 8'hF0);
        chk("f0_start", vz_start, 16'h7AE9);

        // F1 load, alternate magic, slow RAM
        mem.delete();
        wr_cnt = 0;
        ack_delay = 7;
        build_hdr(32'h20200000, 8'hF1, 16'h8000);
        q.push_back(8'hC1);
        q.push_back(8'hC2);
        q.push_back(8'hC3);
        d0 = done_cnt;
        w0 = wait_hi;
        load_file(8'd1);
        chk("f1_8000", rd(16'h8000), 9'h0C1);
        chk("f1_8001", rd(16'h8001), 9'h0C2);
        chk("f1_8002", rd(16'h8002), 9'h0C3);
        chk("f1_usr_lo", rd(16'h788E), 9'h000);
        chk("f1_usr_hi", rd(16'h788F), 9'h080);
        chk("f1_no_basic", rd(16'h78F9), 9'h1FF);
        chk("f1_wait_held", (wait_hi - w0) >= 21, 1);
        chk("f1_done", done_cnt - d0, 1);
        ack_delay = 0;

        // Bad magic
        mem.delete();
        wr_cnt = 0;
        build_hdr(32'h41424344, 8'hF0, 16'h7AE9);
        q.push_back(8'h99);
        q.push_back(8'h98);
        d0 = done_cnt;
        load_file(8'd1);
        chk("magic_writes", wr_cnt, 0);
        chk("magic_err", load_err, 1);
        chk("magic_busy", busy, 0);
        chk("magic_done", done_cnt - d0, 0);

        // Bad type byte
        build_hdr(32'h565A4630, 8'h42, 16'h7AE9);
        load_file(8'd1);
        chk("type_err", load_err, 1);
        chk("type_writes", wr_cnt, 0);

        // Truncated header
        build_hdr(32'h565A4630, 8'hF0, 16'h7AE9);
        while (q.size() > 10)
            void'(q.pop_back());
        d0 = done_cnt;
        load_file(8'd1);
        chk("short_err", load_err, 1);
        chk("short_done", done_cnt - d0, 0);

        // Foreign index is ignored
        build_hdr(32'h565A4630, 8'hF0, 16'h7AE9);
        q.push_back(8'h77);
        busy_seen = 1'b0;
        load_file(8'd0);
        chk("idx0_busy", busy_seen, 0);
        chk("idx0_writes", wr_cnt, 0);

        // Address wrap
        build_hdr(32'h565A4630, 8'hF0, 16'hFFFE);
        for (int i = 0; i < 4; i++)
            q.push_back(8'hA0 + 8'(i));
        d0 = done_cnt;
        load_file(8'd1);
        chk("wrap_fffe", rd(16'hFFFE), 9'h0A0);
        chk("wrap_ffff", rd(16'hFFFF), 9'h0A1);
        chk("wrap_0000", rd(16'h0000), 9'h0A2);
        chk("wrap_0001", rd(16'h0001), 9'h0A3);
        chk("wrap_ptr_lo", rd(16'h78F9), 9'h002);
        chk("wrap_ptr_hi", rd(16'h78FA), 9'h000);
        chk("wrap_err", load_err, 0);
        chk("wrap_done", done_cnt - d0, 1);

        // Reset in the middle of the payload
        mem.delete();
        wr_cnt = 0;
        build_hdr(32'h565A4630, 8'hF0, 16'h7AE9);
        q.push_back(8'h5A);
        q.push_back(8'h5B);
        start_dl(8'd1);
        foreach (q[i])
            send_byte(q[i], 16'(i));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        dn_download = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            {busy, ram_we, dn_wait, load_err, load_done, vz_type, vz_start},
            '0);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_payload", {rd(16'h7AE9), rd(16'h7AEA)},
            {9'h05A, 9'h05B});
        chk("rst_mid_nopatch", rd(16'h78F9), 9'h1FF);
        chk("rst_mid_writes", wr_cnt, 2);

        build_hdr(32'h565A4630, 8'hF1, 16'h9000);
        q.push_back(8'h3C);
        d0 = done_cnt;
        load_file(8'd1);
        chk("post_rst_data", rd(16'h9000), 9'h03C);
        chk("post_rst_usr", {rd(16'h788E), rd(16'h788F)},
            {9'h000, 9'h090});
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", load_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
